// File: rtl/truncon_pkg.sv
// Shared definitions for the truncon equal-flag monitor.
//   DATA_W_DEF   : default vector width (matches truncon outVec)
//   skid_state_e : occupancy state of the 2-entry skid buffer
//   sat_inc      : saturating increment, held at max_v once reached
package truncon_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/truncon_eq_monitor_if.sv
// Stream bundle around the monitor stage.
//   in_valid/in_ready/in_vec/in_equal    : upstream (truncon) side
//   out_valid/out_ready/out_vec/out_equal: downstream side
// master = environment (drives inputs, consumes outputs); slave = monitor.
interface truncon_eq_monitor_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_vec;
  logic              in_equal;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_vec;
  logic              out_equal;

  modport master (
    output in_valid, in_vec, in_equal, out_ready,
    input  in_ready, out_valid, out_vec, out_equal
  );

  modport slave (
    input  in_valid, in_vec, in_equal, out_ready,
    output in_ready, out_valid, out_vec, out_equal
  );
endinterface

// File: rtl/skid_buffer.sv
// Two-entry skid buffer with fully registered handshake outputs.
//   clk, rst            : clock, synchronous active-high reset
//   valid_i/ready_o     : upstream handshake, data_i payload
//   valid_o/ready_i     : downstream handshake, data_o payload
// main_q always holds the head entry; skid_q holds the second entry
// only while the buffer is FULL.
module skid_buffer
  import truncon_pkg::*;
#(
  parameter int W = DATA_W_DEF + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);

  skid_state_e  state_q, state_d;
  logic [W-1:0] main_q, skid_q;
  logic         in_ready_q, out_valid_q;
  logic         accept, emit;

  assign accept = valid_i & in_ready_q;
  assign emit   = out_valid_q & ready_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: if (accept) state_d = ST_ONE;
      ST_ONE: begin
        if (accept && !emit)      state_d = ST_FULL;
        else if (!accept && emit) state_d = ST_EMPTY;
      end
      ST_FULL:  if (emit) state_d = ST_ONE;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_q      <= '0;
      skid_q      <= '0;
    end else begin
      state_q     <= state_d;
      // Handshake flags are registered copies of the next occupancy.
      in_ready_q  <= (state_d != ST_FULL);
      out_valid_q <= (state_d != ST_EMPTY);
      if (state_q == ST_FULL) begin
        if (emit) main_q <= skid_q;
      end else if (accept && (state_q == ST_EMPTY || emit)) begin
        main_q <= data_i;
      end
      // Head is stalled and a new word arrives: park it behind the head.
      if (state_q == ST_ONE && accept && !emit) skid_q <= data_i;
    end
  end

  assign ready_o = in_ready_q;
  assign valid_o = out_valid_q;
  assign data_o  = main_q;

endmodule

// File: rtl/truncon_eq_monitor.sv
// Registered stage behind truncon: forwards {vec, equal} through a skid
// buffer and keeps saturating statistics on the equal flag.
//   clk, rst, clr : clock, sync active-high reset, sync statistics clear
//   bus           : stream interface (slave side)
//   total_cnt     : accepted samples
//   eq_cnt        : accepted samples with equal=1
//   run_len       : current run of consecutive equal=1
//   max_run       : longest run since reset/clr
//   run_alarm     : run_len >= RUN_THRESH
module truncon_eq_monitor
  import truncon_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int CNT_W      = 16,
  parameter int RUN_THRESH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  truncon_eq_monitor_if.slave  bus,
  output logic [CNT_W-1:0]     total_cnt,
  output logic [CNT_W-1:0]     eq_cnt,
  output logic [CNT_W-1:0]     run_len,
  output logic [CNT_W-1:0]     max_run,
  output logic                 run_alarm
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);
  localparam logic [31:0] THRESH  = 32'(RUN_THRESH);

  logic [DATA_W:0] skid_out;
  logic            accept;

  skid_buffer #(.W(DATA_W + 1)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .valid_i (bus.in_valid),
    .ready_o (bus.in_ready),
    .data_i  ({bus.in_equal, bus.in_vec}),
    .valid_o (bus.out_valid),
    .ready_i (bus.out_ready),
    .data_o  (skid_out)
  );

  assign bus.out_equal = skid_out[DATA_W];
  assign bus.out_vec   = skid_out[DATA_W-1:0];
  assign accept        = bus.in_valid & bus.in_ready;

  logic [CNT_W-1:0] total_q, eq_q, run_q, max_q;
  logic [CNT_W-1:0] total_d, eq_d, run_d, max_d;
  logic [CNT_W-1:0] base_total, base_eq, base_run, base_max;
  logic             alarm_q, alarm_d;

  always_comb begin
    // clr zeroes the base first so a coincident sample lands on fresh counters.
    base_total = clr ? '0 : total_q;
    base_eq    = clr ? '0 : eq_q;
    base_run   = clr ? '0 : run_q;
    base_max   = clr ? '0 : max_q;
    total_d    = base_total;
    eq_d       = base_eq;
    run_d      = base_run;
    max_d      = base_max;
    alarm_d    = clr ? 1'b0 : alarm_q;
    if (accept) begin
      total_d = CNT_W'(sat_inc(32'(base_total), CNT_MAX));
      eq_d    = bus.in_equal ? CNT_W'(sat_inc(32'(base_eq), CNT_MAX)) : base_eq;
      run_d   = bus.in_equal ? CNT_W'(sat_inc(32'(base_run), CNT_MAX)) : '0;
      max_d   = (run_d > base_max) ? run_d : base_max;
      alarm_d = (32'(run_d) >= THRESH);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      total_q <= '0;
      eq_q    <= '0;
      run_q   <= '0;
      max_q   <= '0;
      alarm_q <= 1'b0;
    end else begin
      total_q <= total_d;
      eq_q    <= eq_d;
      run_q   <= run_d;
      max_q   <= max_d;
      alarm_q <= alarm_d;
    end
  end

  assign total_cnt = total_q;
  assign eq_cnt    = eq_q;
  assign run_len   = run_q;
  assign max_run   = max_q;
  assign run_alarm = alarm_q;

endmodule

// File: tb/tb_truncon_eq_monitor.sv
module tb_truncon_eq_monitor;
  import truncon_pkg::*;

  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic clr_b = 1'b0;
  always #5 clk = ~clk;

  truncon_eq_monitor_if #(.DATA_W(DW)) ifa ();
  truncon_eq_monitor_if #(.DATA_W(DW)) ifb ();

  logic [15:0] a_total, a_eq, a_run, a_max;
  logic        a_alarm;
  logic [1:0]  b_total, b_eq, b_run, b_max;
  logic        b_alarm;

  truncon_eq_monitor #(.DATA_W(DW), .CNT_W(16), .RUN_THRESH(3)) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .bus(ifa.slave),
    .total_cnt(a_total), .eq_cnt(a_eq), .run_len(a_run), .max_run(a_max),
    .run_alarm(a_alarm)
  );

  truncon_eq_monitor #(.DATA_W(DW), .CNT_W(2), .RUN_THRESH(3)) dut_b (
    .clk(clk), .rst(rst), .clr(clr_b), .bus(ifb.slave),
    .total_cnt(b_total), .eq_cnt(b_eq), .run_len(b_run), .max_run(b_max),
    .run_alarm(b_alarm)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard for dut_a ----------------
  typedef struct { logic [7:0] vec; logic eq; } item_t;
  item_t q[$];
  int m_total, m_eq, m_run, m_max;
  bit m_alarm;
  bit m_ok = 1'b0;

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  always @(negedge clk) begin
    if (m_ok) begin
      chk("a_out_valid", 32'(ifa.out_valid), 32'(q.size() > 0));
      chk("a_in_ready",  32'(ifa.in_ready),  32'(q.size() < 2));
      if (q.size() > 0) begin
        chk("a_out_vec",   32'(ifa.out_vec),   32'(q[0].vec));
        chk("a_out_equal", 32'(ifa.out_equal), 32'(q[0].eq));
      end
      chk("a_total_cnt", 32'(a_total), 32'(sat16(m_total)));
      chk("a_eq_cnt",    32'(a_eq),    32'(sat16(m_eq)));
      chk("a_run_len",   32'(a_run),   32'(sat16(m_run)));
      chk("a_max_run",   32'(a_max),   32'(sat16(m_max)));
      chk("a_run_alarm", 32'(a_alarm), 32'(m_alarm));
    end
    if (rst) begin
      q.delete();
      m_total = 0; m_eq = 0; m_run = 0; m_max = 0; m_alarm = 1'b0;
      m_ok = 1'b1;
    end else if (m_ok) begin
      if (ifa.out_valid && ifa.out_ready && q.size() > 0) void'(q.pop_front());
      if (clr) begin
        m_total = 0; m_eq = 0; m_run = 0; m_max = 0; m_alarm = 1'b0;
      end
      if (ifa.in_valid && ifa.in_ready) begin
        q.push_back('{vec: ifa.in_vec, eq: ifa.in_equal});
        m_total++;
        if (ifa.in_equal) begin
          m_eq++;
          m_run++;
        end else begin
          m_run = 0;
        end
        if (m_run > m_max) m_max = m_run;
        m_alarm = (m_run >= 3);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_a(input logic [7:0] v, input logic e);
    ifa.in_valid = 1'b1;
    ifa.in_vec   = v;
    ifa.in_equal = e;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ifa.in_ready) begin
        @(posedge clk); #1;
        ifa.in_valid = 1'b0;
        clr = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    n_tests++;
    n_fail++;
    $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 50 cycles");
    ifa.in_valid = 1'b0;
  endtask

  initial begin
    ifa.in_valid = 1'b0; ifa.in_vec = '0; ifa.in_equal = 1'b0; ifa.out_ready = 1'b0;
    ifb.in_valid = 1'b0; ifb.in_vec = '0; ifb.in_equal = 1'b0; ifb.out_ready = 1'b0;

    // 1: reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_vec",   32'(ifa.out_vec), 32'h0);
    chk("rst_out_equal", 32'(ifa.out_equal), 32'h0);
    chk("rst_b_total",   32'(b_total), 32'h0);
    @(posedge clk); #1;

    // 2: back-to-back with free-flowing output
    ifa.out_ready = 1'b1;
    send_a(8'hCC, 1'b1);
    send_a(8'hAA, 1'b0);
    send_a(8'h55, 1'b1);
    @(negedge clk);
    chk("t2_total", 32'(a_total), 32'd3);
    chk("t2_eq",    32'(a_eq),    32'd2);
    chk("t2_run",   32'(a_run),   32'd1);
    chk("t2_max",   32'(a_max),   32'd1);
    repeat (2) @(posedge clk); #1;

    // 3: backpressure fills the buffer, then drains in order
    ifa.out_ready = 1'b0;
    send_a(8'h01, 1'b0);
    send_a(8'h02, 1'b0);
    fork
      send_a(8'h03, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1 ifa.out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk); #1;

    // 4: run of four equal hits, then a miss
    for (int i = 0; i < 4; i++) send_a(8'h10 + 8'(i), 1'b1);
    @(negedge clk);
    chk("t4_alarm_hi", 32'(a_alarm), 32'd1);
    @(posedge clk); #1;
    send_a(8'h20, 1'b0);
    @(negedge clk);
    chk("t4_run0",  32'(a_run),   32'd0);
    chk("t4_alarm", 32'(a_alarm), 32'd0);
    chk("t4_max",   32'(a_max),   32'd4);
    @(posedge clk); #1;

    // 5: clear coincident with an accept
    clr = 1'b1;
    send_a(8'h33, 1'b1);
    @(negedge clk);
    chk("t5_total", 32'(a_total), 32'd1);
    chk("t5_eq",    32'(a_eq),    32'd1);
    chk("t5_run",   32'(a_run),   32'd1);
    chk("t5_max",   32'(a_max),   32'd1);
    @(posedge clk); #1;

    // 6: CNT_W=2 instance saturates at 3
    begin
      int acc;
      acc = 0;
      ifb.out_ready = 1'b1;
      ifb.in_valid  = 1'b1;
      ifb.in_equal  = 1'b1;
      ifb.in_vec    = 8'h77;
      for (int i = 0; i < 20 && acc < 5; i++) begin
        @(negedge clk);
        if (ifb.in_ready) acc++;
        @(posedge clk); #1;
      end
      ifb.in_valid = 1'b0;
      chk("t6_accepts", 32'(acc), 32'd5);
      @(negedge clk);
      chk("t6_total", 32'(b_total), 32'd3);
      chk("t6_eq",    32'(b_eq),    32'd3);
      chk("t6_run",   32'(b_run),   32'd3);
      chk("t6_max",   32'(b_max),   32'd3);
      chk("t6_alarm", 32'(b_alarm), 32'd1);
      @(posedge clk); #1;
    end

    // Randomized traffic with backpressure, clears and occasional resets
    begin
      bit pending;
      pending = 1'b0;
      for (int c = 0; c < 600; c++) begin
        if (!pending) begin
          ifa.in_valid = ($urandom % 4) != 0;
          ifa.in_vec   = 8'($urandom);
          ifa.in_equal = ($urandom % 3) != 0;
        end
        ifa.out_ready = ($urandom % 3) != 0;
        clr = ($urandom % 50) == 0;
        rst = ($urandom % 200) == 0;
        @(negedge clk);
        pending = ifa.in_valid && !ifa.in_ready;
        @(posedge clk); #1;
      end
    end
    rst = 1'b0;
    clr = 1'b0;
    ifa.in_valid = 1'b0;
    ifa.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("drain_out_valid", 32'(ifa.out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

endmodule
